ctrl_pipeline: RTL
==================

Name: ctrl_pipeline

Overview:
- Sequential successor to the combinational main decoder for the pipelined LEGv8 core.
- Decodes the 32-bit instruction in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles, honours external hold and flush, and flags illegal opcodes instead of emitting X controls.
- Widths and link register are parameterised; load-use interlock is selectable by mode.

Parameters:
- REG_W, 5, register-address width (Rd/Rn/Rm fields).
- ALUOP_W, 3, ALU operation code width.
- LINK_REG, 30, register written by BL.
- ZERO_REG, 31, hardwired-zero register; never causes a hazard and never written.
- INTERLOCK, 1, 1 = hardware load-use stall; 0 = no stall (software delay-slot rule).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_instr  in  32  instruction currently in ID
- id_valid  in  1  id_instr is a real instruction
- hold  in  1  freeze every pipeline register (memory wait)
- flush_id  in  1  convert the ID instruction to a bubble
- id_reg2loc  out  1  combinational: 0 = read Rd on port B, 1 = read Rm
- id_stall  out  1  combinational: freeze PC and IF/ID this cycle
- ex_valid  out  1  EX stage holds a real instruction
- ex_alu_src  out  1  1 = immediate operand
- ex_alu_op  out  ALUOP_W  ALU operation
- ex_imm12_sel  out  1  1 = ADDI zero-extended Imm12; 0 = DAddr9
- ex_flag_wr_en  out  1  write NZCV this cycle
- mem_valid  out  1  MEM stage holds a real instruction
- mem_write  out  1  data-memory write strobe
- mem_read  out  1  data-memory read
- wb_valid  out  1  WB stage holds a real instruction
- wb_reg_write  out  1  register-file write enable
- wb_mem_to_reg  out  1  select memory data
- wb_link  out  1  select PC+4 as write data (BL)
- wb_rd  out  REG_W  destination register
- illegal  out  1  sticky: an unknown opcode reached EX

Behaviour:
- Decode uses id_instr[31:21]:
  - ADDI 1001000100x: alu_src=1, imm12_sel=1, reg_write=1, op=010.
  - ADDS 10101011000: reg2loc=1, reg_write=1, op=010, flag_wr_en=1.
  - SUBS 11101011000: reg2loc=1, reg_write=1, op=011, flag_wr_en=1.
  - LDUR 11111000010: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, op=010.
  - STUR 11111000000: alu_src=1, mem_write=1, op=010.
  - CBZ 10110100xxx and BR 11010110000: reg2loc=0, op=000, no writes.
  - B.LT 01010100xxx and B 000101xxxxx: no writes.
  - BL 100101xxxxx: reg_write=1, link=1, rd=LINK_REG.
- Every control output is fully defined; no X values. Unlisted controls are 0.
- Unknown opcode: bubble with all writes 0. illegal sets when it reaches EX and clears only on reset.
- The destination is 0 for STUR, CBZ, B, B.LT and BR. If the decoded rd equals ZERO_REG, reg_write is forced to 0.
- Latency: ex_* follow id_instr 1 cycle later, mem_* after 2 cycles, wb_* after 3 cycles.
- Each stage valid qualifies its strobes. When a stage is invalid, its write, read and flag strobes are 0.
- Reads-register sets used for hazard detection:
  - ADDI, LDUR: Rn.
  - ADDS, SUBS: Rn, Rm.
  - STUR: Rn, Rd.
  - CBZ, BR: Rd.
  - B, B.LT, BL: none.
- Load-use hazard (INTERLOCK=1) when all of the following hold:
  - ex_valid and the EX instruction is LDUR with rd != ZERO_REG;
  - id_valid;
  - the ID instruction reads that rd.
- On a load-use hazard: id_stall=1 and a bubble enters EX next cycle. One stall cycle only, because the load then sits in MEM.
- INTERLOCK=0: id_stall is tied to 0.
- Priority order: reset > hold > flush_id > load-use.
  - hold=1: all stage registers keep their values; id_stall=1; illegal cannot newly set.
  - flush_id=1: a bubble enters EX and id_stall=0.
  - flush_id and a hazard in the same cycle: the flush wins.
- Reset: all valids, strobes, wb_rd and illegal go to 0 on the next clk edge. Reset mid-stall cancels the stall, and id_stall reads 0 while reset=1.

Test Plan:
- Reset, then stream ADDS X3,X1,X4 (0xAB040023) -> ex_flag_wr_en=1 and op=010 at cycle+1; wb_reg_write=1 and wb_rd=3 at cycle+3.
- LDUR X1,[X2,#0] (0xF8400041) followed by ADDS X3,X1,X4 -> id_stall=1 for exactly 1 cycle and ex_valid=0 for that bubble. With INTERLOCK=0 there is no stall.
- LDUR X31,[X2] followed by a reader of X31 -> no stall, and wb_reg_write=0.
- BL (0x94000004) -> wb_link=1, wb_rd=30, wb_reg_write=1. Opcode 0x00000000 -> illegal=1 from cycle+1 with no writes; illegal clears only after reset.
- hold=1 for 3 cycles mid-stream -> all ex/mem/wb outputs constant; execution resumes unchanged after hold.
- flush_id asserted during a load-use hazard -> id_stall=0 and a bubble enters EX. Reset asserted during a stall -> all valids 0 next edge.

Source files
------------

// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if
//   Bundles the ID-stage inputs and the staged control outputs of
//   ctrl_pipeline so that the core and the decoder share one connection.
//   master : drives id_instr/id_valid/hold/flush_id and observes controls.
//   slave  : the decoder/pipeline itself.
interface ctrl_pipeline_if #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned ALUOP_W = 3
);
    logic [31:0]        id_instr;
    logic               id_valid;
    logic               hold;
    logic               flush_id;

    logic               id_reg2loc;
    logic               id_stall;

    logic               ex_valid;
    logic               ex_alu_src;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic               ex_imm12_sel;
    logic               ex_flag_wr_en;

    logic               mem_valid;
    logic               mem_write;
    logic               mem_read;

    logic               wb_valid;
    logic               wb_reg_write;
    logic               wb_mem_to_reg;
    logic               wb_link;
    logic [REG_W-1:0]   wb_rd;

    logic               illegal;

    modport master (
        output id_instr, id_valid, hold, flush_id,
        input  id_reg2loc, id_stall,
               ex_valid, ex_alu_src, ex_alu_op, ex_imm12_sel, ex_flag_wr_en,
               mem_valid, mem_write, mem_read,
               wb_valid, wb_reg_write, wb_mem_to_reg, wb_link, wb_rd,
               illegal
    );

    modport slave (
        input  id_instr, id_valid, hold, flush_id,
        output id_reg2loc, id_stall,
               ex_valid, ex_alu_src, ex_alu_op, ex_imm12_sel, ex_flag_wr_en,
               mem_valid, mem_write, mem_read,
               wb_valid, wb_reg_write, wb_mem_to_reg, wb_link, wb_rd,
               illegal
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
//   LEGv8 main decoder with the control bundle carried through the
//   ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards,
//   honours hold (full freeze) and flush_id (ID becomes a bubble), and
//   turns unknown opcodes into bubbles while raising a sticky illegal flag.
// Ports
//   clk, reset : clock, synchronous active-high reset
//   bus        : ctrl_pipeline_if.slave
//                in  id_instr, id_valid, hold, flush_id
//                out id_reg2loc, id_stall (combinational)
//                out ex_*, mem_*, wb_* stage controls, illegal (registered)
module ctrl_pipeline #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned ALUOP_W   = 3,
    parameter int unsigned LINK_REG  = 30,
    parameter int unsigned ZERO_REG  = 31,
    parameter int unsigned INTERLOCK = 1
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_pipeline_if.slave bus
);

    localparam logic [REG_W-1:0]   ZERO_A = REG_W'(ZERO_REG);
    localparam logic [REG_W-1:0]   LINK_A = REG_W'(LINK_REG);
    localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(3'b011);

    typedef struct packed {
        logic               valid;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               imm12_sel;
        logic               flag_wr_en;
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic               mem_to_reg;
        logic               link;
        logic [REG_W-1:0]   rd;
    } ex_t;

    typedef struct packed {
        logic             valid;
        logic             mem_write;
        logic             mem_read;
        logic             reg_write;
        logic             mem_to_reg;
        logic             link;
        logic [REG_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             mem_to_reg;
        logic             link;
        logic [REG_W-1:0] rd;
    } wb_t;

    ex_t  ex_q;
    mem_t mem_q;
    wb_t  wb_q;
    logic illegal_q;

    ex_t              dec;
    logic             known;
    logic             reads_rn;
    logic             reads_rm;
    logic             reads_rd;
    logic             reg2loc;
    logic             load_use;
    logic [10:0]      op11;
    logic [REG_W-1:0] f_rd;
    logic [REG_W-1:0] f_rn;
    logic [REG_W-1:0] f_rm;
    logic             unused_imm_bits;

    assign op11 = bus.id_instr[31:21];
    assign f_rd = REG_W'(bus.id_instr[4:0]);
    assign f_rn = REG_W'(bus.id_instr[9:5]);
    assign f_rm = REG_W'(bus.id_instr[20:16]);
    // Immediate/shamt bits never influence control or hazards.
    assign unused_imm_bits = ^bus.id_instr[15:10];

    always_comb begin
        dec      = '0;
        known    = 1'b1;
        reads_rn = 1'b0;
        reads_rm = 1'b0;
        reads_rd = 1'b0;
        reg2loc  = 1'b0;
        casez (op11)
            11'b1001000100?: begin // ADDI
                dec.alu_src   = 1'b1;
                dec.imm12_sel = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = OP_ADD;
                dec.rd        = f_rd;
                reads_rn      = 1'b1;
            end
            11'b10101011000: begin // ADDS
                reg2loc        = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = OP_ADD;
                dec.flag_wr_en = 1'b1;
                dec.rd         = f_rd;
                reads_rn       = 1'b1;
                reads_rm       = 1'b1;
            end
            11'b11101011000: begin // SUBS
                reg2loc        = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = OP_SUB;
                dec.flag_wr_en = 1'b1;
                dec.rd         = f_rd;
                reads_rn       = 1'b1;
                reads_rm       = 1'b1;
            end
            11'b11111000010: begin // LDUR
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_op     = OP_ADD;
                dec.rd         = f_rd;
                reads_rn       = 1'b1;
            end
            11'b11111000000: begin // STUR
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = OP_ADD;
                reads_rn      = 1'b1;
                reads_rd      = 1'b1;
            end
            11'b10110100???, 11'b11010110000: begin // CBZ, BR
                reads_rd = 1'b1;
            end
            11'b01010100???, 11'b000101?????: begin // B.cond, B
                known = 1'b1;
            end
            11'b100101?????: begin // BL
                dec.reg_write = 1'b1;
                dec.link      = 1'b1;
                dec.rd        = LINK_A;
            end
            default: known = 1'b0;
        endcase
        if (dec.rd == ZERO_A) begin
            dec.reg_write = 1'b0;
        end
        dec.valid = bus.id_valid & known;
        if (!dec.valid) begin
            dec = '0;
        end
    end

    always_comb begin
        load_use = 1'b0;
        if ((INTERLOCK != 0) && ex_q.valid && ex_q.mem_read &&
            (ex_q.rd != ZERO_A) && bus.id_valid) begin
            load_use = (reads_rn && (f_rn == ex_q.rd)) ||
                       (reads_rm && (f_rm == ex_q.rd)) ||
                       (reads_rd && (f_rd == ex_q.rd));
        end
    end

    // Hold freezes the front end too; flush discards ID so there is
    // nothing left to stall for.
    assign bus.id_stall   = !reset && (bus.hold || (load_use && !bus.flush_id));
    assign bus.id_reg2loc = reg2loc;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else if (!bus.hold) begin
            wb_q  <= '{valid: mem_q.valid, reg_write: mem_q.reg_write,
                       mem_to_reg: mem_q.mem_to_reg, link: mem_q.link,
                       rd: mem_q.rd};
            mem_q <= '{valid: ex_q.valid, mem_write: ex_q.mem_write,
                       mem_read: ex_q.mem_read, reg_write: ex_q.reg_write,
                       mem_to_reg: ex_q.mem_to_reg, link: ex_q.link,
                       rd: ex_q.rd};
            if (bus.flush_id || load_use) begin
                ex_q <= '0;
            end else begin
                ex_q <= dec;
                if (bus.id_valid && !known) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_imm12_sel  = ex_q.imm12_sel;
    assign bus.ex_flag_wr_en = ex_q.flag_wr_en;
    assign bus.mem_valid     = mem_q.valid;
    assign bus.mem_write     = mem_q.mem_write;
    assign bus.mem_read      = mem_q.mem_read;
    assign bus.wb_valid      = wb_q.valid;
    assign bus.wb_reg_write  = wb_q.reg_write;
    assign bus.wb_mem_to_reg = wb_q.mem_to_reg;
    assign bus.wb_link       = wb_q.link;
    assign bus.wb_rd         = wb_q.rd;
    assign bus.illegal       = illegal_q;

endmodule
